// File: rtl/sb_dac_fifo.sv
// sb_dac_fifo: sound output device fed by the 8-bit DMA channel 1 engine.
// Bytes arrive over a toggle handshake and are buffered in a small FIFO.
// A programmable divider releases one unsigned sample per tick to the DAC/PWM.
// If the FIFO is empty on a tick, a sticky underrun flag is set and an
// interrupt toggle is raised.
//
// Ports:
//   clk, reset_n           system clock, asynchronous active-low reset
//   port, iodin, iowrin    toggle-strobed I/O write bus (rate/control registers)
//   iowrout                I/O ack toggle, a registered copy of iowrin
//   dma_din, dma_wrin      byte and request toggle from the DMA engine
//   dma_wrout              ack toggle back to the DMA engine
//   sample_out, sample_stb current sample and its one-cycle update pulse
//   fifo_level             number of bytes held (0..DEPTH)
//   underrun, irq_out      sticky underrun flag and per-event interrupt toggle
`timescale 1ns/1ps

module sb_dac_fifo #(
    parameter int          DEPTH        = 16,
    parameter logic [11:0] PORT_RATE_LO = 12'h22A,
    parameter logic [11:0] PORT_RATE_HI = 12'h22B,
    parameter logic [11:0] PORT_CTRL    = 12'h22C
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [11:0]              port,
    input  logic [7:0]               iodin,
    input  logic                     iowrin,
    output logic                     iowrout,
    input  logic [7:0]               dma_din,
    input  logic                     dma_wrin,
    output logic                     dma_wrout,
    output logic [7:0]               sample_out,
    output logic                     sample_stb,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     underrun,
    output logic                     irq_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [15:0]   rate;
    logic [15:0]   div_count;
    logic          enable;

    logic io_stb;
    logic rate_lo_wr;
    logic rate_hi_wr;
    logic ctrl_wr;
    logic flush;
    logic clr_under;
    logic tick;
    logic dma_pend;
    logic push_ok;
    logic store;
    logic pop;
    logic starve;

    // A strobe is pending exactly when the request toggle differs from our ack.
    assign io_stb     = iowrin ^ iowrout;
    assign rate_lo_wr = io_stb && (port == PORT_RATE_LO);
    assign rate_hi_wr = io_stb && (port == PORT_RATE_HI);
    assign ctrl_wr    = io_stb && (port == PORT_CTRL);
    assign flush      = ctrl_wr && iodin[1];
    assign clr_under  = ctrl_wr && iodin[2];

    // Flush overrides any tick in the same cycle: nothing is popped and no
    // underrun is raised while the FIFO is being emptied.
    assign tick   = enable && (div_count == rate);
    assign pop    = tick && (fifo_level != '0) && !flush;
    assign starve = tick && (fifo_level == '0) && !flush;

    // Push eligibility uses the level before any pop, so a full FIFO never
    // accepts a byte in the same cycle it frees a slot. A flush still acks
    // the byte but drops it.
    assign dma_pend = dma_wrin ^ dma_wrout;
    assign push_ok  = dma_pend && (fifo_level < FULL_LEVEL);
    assign store    = push_ok && !flush;

    // I/O ack and programmable registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iowrout <= 1'b0;
            rate    <= 16'hFFFF;
            enable  <= 1'b0;
        end else begin
            iowrout <= iowrin;
            if (rate_lo_wr) rate[7:0]  <= iodin;
            if (rate_hi_wr) rate[15:8] <= iodin;
            if (ctrl_wr)    enable     <= iodin[0];
        end
    end

    // DMA ack toggle; withheld while the FIFO is full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dma_wrout <= 1'b0;
        end else if (push_ok) begin
            dma_wrout <= dma_wrin;
        end
    end

    // Playback divider. If the rate is lowered below the current count the
    // counter simply runs on and wraps through 16'hFFFF.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_count <= '0;
        end else if (flush || !enable || tick) begin
            div_count <= '0;
        end else begin
            div_count <= div_count + 16'd1;
        end
    end

    // Sample storage, write only; no reset needed.
    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= dma_din;
    end

    // FIFO pointers, level and the registered sample output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            sample_out <= 8'h80;
            sample_stb <= 1'b0;
        end else begin
            sample_stb <= pop;
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_level <= '0;
                sample_out <= 8'h80;
            end else begin
                if (store) wr_ptr <= wr_ptr + PW'(1);
                if (pop) begin
                    rd_ptr     <= rd_ptr + PW'(1);
                    sample_out <= mem[rd_ptr];
                end
                case ({store, pop})
                    2'b10:   fifo_level <= fifo_level + LW'(1);
                    2'b01:   fifo_level <= fifo_level - LW'(1);
                    default: fifo_level <= fifo_level;
                endcase
            end
        end
    end

    // Underrun flag. The interrupt toggles once per event: on a rising flag,
    // or when a clear and a new underrun land in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun <= 1'b0;
            irq_out  <= 1'b0;
        end else if (starve) begin
            underrun <= 1'b1;
            if (!underrun || clr_under) irq_out <= ~irq_out;
        end else if (clr_under) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sb_dac_fifo.sv
// tb_sb_dac_fifo: self-checking bench for sb_dac_fifo.
// A queue-based reference model tracks the expected FIFO contents, tick timing,
// underrun/irq behaviour and handshake acks; scenario tasks drive stimulus on
// the falling edge and compare DUT outputs against the model or constants.
`timescale 1ns/1ps

module tb_sb_dac_fifo;

    localparam int          DEPTH  = 16;
    localparam logic [11:0] P_LO   = 12'h22A;
    localparam logic [11:0] P_HI   = 12'h22B;
    localparam logic [11:0] P_CTRL = 12'h22C;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] port = '0;
    logic [7:0]  iodin = '0;
    logic        iowrin = 1'b0;
    logic        iowrout;
    logic [7:0]  dma_din = '0;
    logic        dma_wrin = 1'b0;
    logic        dma_wrout;
    logic [7:0]  sample_out;
    logic        sample_stb;
    logic [4:0]  fifo_level;
    logic        underrun;
    logic        irq_out;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [7:0] stb_val[$];
    int         stb_cyc[$];

    sb_dac_fifo #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .port       (port),
        .iodin      (iodin),
        .iowrin     (iowrin),
        .iowrout    (iowrout),
        .dma_din    (dma_din),
        .dma_wrin   (dma_wrin),
        .dma_wrout  (dma_wrout),
        .sample_out (sample_out),
        .sample_stb (sample_stb),
        .fifo_level (fifo_level),
        .underrun   (underrun),
        .irq_out    (irq_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every sample release with its cycle number.
    always @(negedge clk) begin
        if (sample_stb === 1'b1) begin
            stb_val.push_back(sample_out);
            stb_cyc.push_back(cyc);
        end
    end

    // Reference model state.
    logic [7:0]  m_q[$];
    logic [15:0] m_rate = 16'hFFFF;
    logic        m_enable = 1'b0;
    int          m_count = 0;
    logic [7:0]  m_sample = 8'h80;
    logic        m_stb = 1'b0;
    logic        m_under = 1'b0;
    logic        m_irq = 1'b0;
    logic        m_dma_ack = 1'b0;
    logic        m_io_ack = 1'b0;
    int          m_pre;
    bit          m_tick, m_flush, m_clr, m_want, m_strobe;

    // Model step: each clock applies the rules to the inputs seen at the edge.
    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_q.delete();
                m_rate = 16'hFFFF; m_enable = 1'b0; m_count = 0;
                m_sample = 8'h80; m_stb = 1'b0; m_under = 1'b0; m_irq = 1'b0;
                m_dma_ack = 1'b0; m_io_ack = 1'b0;
            end else begin
                m_strobe = (iowrin != m_io_ack);
                m_flush  = m_strobe && port == P_CTRL && iodin[1];
                m_clr    = m_strobe && port == P_CTRL && iodin[2];
                m_tick   = m_enable && (m_count == int'(m_rate));
                m_pre    = m_q.size();
                m_want   = (dma_wrin != m_dma_ack);
                if (m_flush) begin
                    m_q.delete();
                    m_sample = 8'h80;
                    m_count = 0;
                    m_stb = 1'b0;
                    if (m_want && m_pre < DEPTH) m_dma_ack = dma_wrin;
                    if (m_clr) m_under = 1'b0;
                end else begin
                    if (!m_enable || m_tick) m_count = 0;
                    else m_count = (m_count + 1) % 65536;
                    m_stb = 1'b0;
                    if (m_tick && m_pre > 0) begin
                        m_sample = m_q.pop_front();
                        m_stb = 1'b1;
                    end
                    if (m_want && m_pre < DEPTH) begin
                        m_q.push_back(dma_din);
                        m_dma_ack = dma_wrin;
                    end
                    if (m_tick && m_pre == 0) begin
                        if (!m_under || m_clr) m_irq = ~m_irq;
                        m_under = 1'b1;
                    end else if (m_clr) begin
                        m_under = 1'b0;
                    end
                end
                if (m_strobe && port == P_LO) m_rate[7:0] = iodin;
                if (m_strobe && port == P_HI) m_rate[15:8] = iodin;
                if (m_strobe && port == P_CTRL) m_enable = iodin[0];
                m_io_ack = iowrin;
            end
        end
    end

    task automatic io_write(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        port = a;
        iodin = d;
        iowrin = ~iowrin;
    endtask

    task automatic dma_toggle(input logic [7:0] d);
        @(negedge clk);
        dma_din = d;
        dma_wrin = ~dma_wrin;
    endtask

    // Push one byte and wait (bounded) for its ack.
    task automatic dma_push(input logic [7:0] d);
        int k;
        dma_toggle(d);
        @(negedge clk);
        k = 0;
        while (dma_wrout !== dma_wrin && k < 64) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (dma_wrout !== dma_wrin) begin
            bad++;
            $display("[TB] FAIL dma_ack_timeout got=%b want=%b", dma_wrout, dma_wrin);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (sample_out !== 8'h80) begin bad++; $display("[TB] FAIL reset_sample got=%h want=80", sample_out); end
        total++; if (fifo_level !== 5'd0) begin bad++; $display("[TB] FAIL reset_level got=%0d want=0", fifo_level); end
        total++; if (dma_wrout !== 1'b0) begin bad++; $display("[TB] FAIL reset_dma_ack got=%b want=0", dma_wrout); end
        reset_n = 1'b1;
        @(negedge clk);
        total++; if (iowrout !== 1'b0) begin bad++; $display("[TB] FAIL reset_io_ack got=%b want=0", iowrout); end
        total++; if (sample_stb !== 1'b0) begin bad++; $display("[TB] FAIL reset_stb got=%b want=0", sample_stb); end
        total++; if (underrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_underrun got=%b want=0", underrun); end
        total++; if (irq_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq got=%b want=0", irq_out); end
    endtask

    task automatic test_basic();
        logic [7:0] vals[3];
        vals[0] = 8'h10; vals[1] = 8'h20; vals[2] = 8'h30;
        io_write(P_LO, 8'h03);
        io_write(P_HI, 8'h00);
        io_write(P_CTRL, 8'h01);
        stb_val.delete();
        stb_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            dma_toggle(vals[i]);
            @(negedge clk);
            total++; if (dma_wrout !== dma_wrin) begin bad++; $display("[TB] FAIL basic_ack_latency got=%b want=%b", dma_wrout, dma_wrin); end
            total++; if (iowrout !== m_io_ack) begin bad++; $display("[TB] FAIL basic_io_ack got=%b want=%b", iowrout, m_io_ack); end
        end
        repeat (20) begin
            @(negedge clk);
            total++; if (sample_out !== m_sample) begin bad++; $display("[TB] FAIL basic_sample got=%h want=%h", sample_out, m_sample); end
            total++; if (sample_stb !== m_stb) begin bad++; $display("[TB] FAIL basic_stb got=%b want=%b", sample_stb, m_stb); end
        end
        #1;
        total++;
        if (stb_val.size() != 3) begin
            bad++; $display("[TB] FAIL basic_stb_count got=%0d want=3", stb_val.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++; if (stb_val[i] !== vals[i]) begin bad++; $display("[TB] FAIL basic_order got=%h want=%h", stb_val[i], vals[i]); end
            end
            for (int i = 1; i < 3; i++) begin
                total++; if (stb_cyc[i] - stb_cyc[i-1] != 4) begin bad++; $display("[TB] FAIL basic_tick_period got=%0d want=4", stb_cyc[i] - stb_cyc[i-1]); end
            end
        end
    endtask

    task automatic test_backpressure();
        int stb_at, ack_at;
        logic [7:0] first_val;
        io_write(P_CTRL, 8'h06);
        for (int i = 0; i < DEPTH; i++) dma_push(8'h40 + 8'(i));
        @(negedge clk);
        total++; if (fifo_level !== 5'd16) begin bad++; $display("[TB] FAIL bp_full_level got=%0d want=16", fifo_level); end
        dma_toggle(8'hC7);
        repeat (5) @(negedge clk);
        total++; if (dma_wrout !== ~dma_wrin) begin bad++; $display("[TB] FAIL bp_ack_withheld got=%b want=%b", dma_wrout, ~dma_wrin); end
        total++; if (fifo_level !== 5'd16) begin bad++; $display("[TB] FAIL bp_level_hold got=%0d want=16", fifo_level); end
        io_write(P_CTRL, 8'h01);
        stb_at = -1; ack_at = -1; first_val = 8'h00;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            total++; if (fifo_level !== 5'(m_q.size())) begin bad++; $display("[TB] FAIL bp_level got=%0d want=%0d", fifo_level, m_q.size()); end
            total++; if (dma_wrout !== m_dma_ack) begin bad++; $display("[TB] FAIL bp_ack got=%b want=%b", dma_wrout, m_dma_ack); end
            if (sample_stb === 1'b1 && stb_at < 0) begin stb_at = i; first_val = sample_out; end
            if (dma_wrout === dma_wrin && ack_at < 0) begin
                ack_at = i;
                total++; if (fifo_level !== 5'd16) begin bad++; $display("[TB] FAIL bp_level_after_ack got=%0d want=16", fifo_level); end
            end
        end
        total++; if (stb_at < 0 || ack_at != stb_at + 1) begin bad++; $display("[TB] FAIL bp_ack_timing got=%0d want=%0d", ack_at, stb_at + 1); end
        total++; if (first_val !== 8'h40) begin bad++; $display("[TB] FAIL bp_first_pop got=%h want=40", first_val); end
    endtask

    task automatic test_underrun();
        int toggles;
        logic prev;
        io_write(P_CTRL, 8'h06);
        io_write(P_LO, 8'h01);
        io_write(P_HI, 8'h00);
        io_write(P_CTRL, 8'h01);
        prev = irq_out;
        toggles = 0;
        dma_push(8'hA5);
        repeat (12) begin
            @(negedge clk);
            if (irq_out !== prev) toggles++;
            prev = irq_out;
            total++; if (underrun !== m_under) begin bad++; $display("[TB] FAIL ur_flag got=%b want=%b", underrun, m_under); end
            total++; if (irq_out !== m_irq) begin bad++; $display("[TB] FAIL ur_irq got=%b want=%b", irq_out, m_irq); end
            total++; if (sample_out !== m_sample) begin bad++; $display("[TB] FAIL ur_sample got=%h want=%h", sample_out, m_sample); end
        end
        total++; if (sample_out !== 8'hA5) begin bad++; $display("[TB] FAIL ur_hold_sample got=%h want=a5", sample_out); end
        total++; if (underrun !== 1'b1) begin bad++; $display("[TB] FAIL ur_sticky got=%b want=1", underrun); end
        total++; if (toggles != 1) begin bad++; $display("[TB] FAIL ur_irq_count got=%0d want=1", toggles); end
    endtask

    task automatic test_clear();
        int toggles;
        logic prev;
        prev = irq_out;
        toggles = 0;
        io_write(P_CTRL, 8'h05);
        repeat (12) begin
            @(negedge clk);
            if (irq_out !== prev) toggles++;
            prev = irq_out;
            total++; if (underrun !== m_under) begin bad++; $display("[TB] FAIL clr_flag got=%b want=%b", underrun, m_under); end
            total++; if (irq_out !== m_irq) begin bad++; $display("[TB] FAIL clr_irq got=%b want=%b", irq_out, m_irq); end
        end
        total++; if (toggles != 1) begin bad++; $display("[TB] FAIL clr_irq_count got=%0d want=1", toggles); end
        total++; if (underrun !== 1'b1) begin bad++; $display("[TB] FAIL clr_reset_flag got=%b want=1", underrun); end
    endtask

    task automatic test_flush_push();
        io_write(P_CTRL, 8'h06);
        for (int i = 0; i < 5; i++) dma_push(8'($urandom_range(0, 255)));
        @(negedge clk);
        total++; if (fifo_level !== 5'd5) begin bad++; $display("[TB] FAIL fl_pre_level got=%0d want=5", fifo_level); end
        @(negedge clk);
        port = P_CTRL; iodin = 8'h03; iowrin = ~iowrin;
        dma_din = 8'hEE; dma_wrin = ~dma_wrin;
        stb_val.delete();
        @(negedge clk);
        total++; if (fifo_level !== 5'd0) begin bad++; $display("[TB] FAIL fl_level got=%0d want=0", fifo_level); end
        total++; if (sample_out !== 8'h80) begin bad++; $display("[TB] FAIL fl_sample got=%h want=80", sample_out); end
        total++; if (dma_wrout !== dma_wrin) begin bad++; $display("[TB] FAIL fl_ack got=%b want=%b", dma_wrout, dma_wrin); end
        repeat (8) begin
            @(negedge clk);
            total++; if (sample_out !== 8'h80) begin bad++; $display("[TB] FAIL fl_stale got=%h want=80", sample_out); end
        end
        #1;
        total++; if (stb_val.size() != 0) begin bad++; $display("[TB] FAIL fl_no_stb got=%0d want=0", stb_val.size()); end
    endtask

    task automatic test_random();
        io_write(P_CTRL, 8'h06);
        io_write(P_LO, 8'($urandom_range(0, 3)));
        io_write(P_HI, 8'h00);
        io_write(P_CTRL, 8'h01);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            total++; if (sample_out !== m_sample) begin bad++; $display("[TB] FAIL rnd_sample got=%h want=%h", sample_out, m_sample); end
            total++; if (sample_stb !== m_stb) begin bad++; $display("[TB] FAIL rnd_stb got=%b want=%b", sample_stb, m_stb); end
            total++; if (fifo_level !== 5'(m_q.size())) begin bad++; $display("[TB] FAIL rnd_level got=%0d want=%0d", fifo_level, m_q.size()); end
            total++; if (dma_wrout !== m_dma_ack) begin bad++; $display("[TB] FAIL rnd_dma_ack got=%b want=%b", dma_wrout, m_dma_ack); end
            total++; if (iowrout !== m_io_ack) begin bad++; $display("[TB] FAIL rnd_io_ack got=%b want=%b", iowrout, m_io_ack); end
            total++; if (underrun !== m_under) begin bad++; $display("[TB] FAIL rnd_underrun got=%b want=%b", underrun, m_under); end
            total++; if (irq_out !== m_irq) begin bad++; $display("[TB] FAIL rnd_irq got=%b want=%b", irq_out, m_irq); end
            if (dma_wrin == m_dma_ack && $urandom_range(0, 2) != 0) begin
                dma_din = 8'($urandom_range(0, 255));
                dma_wrin = ~dma_wrin;
            end
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 2))
                    0: begin port = P_LO; iodin = 8'($urandom_range(0, 5)); end
                    1: begin port = 12'h230; iodin = 8'($urandom_range(0, 255)); end
                    default: begin
                        port = P_CTRL;
                        iodin = {5'b0, 1'($urandom_range(0, 1)),
                                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) != 0)};
                    end
                endcase
                iowrin = ~iowrin;
            end
        end
    endtask

    task automatic test_async_reset();
        io_write(P_CTRL, 8'h02);
        for (int i = 0; i < 7; i++) dma_push(8'h60 + 8'(i));
        if (m_dma_ack !== 1'b1) begin
            io_write(P_CTRL, 8'h02);
            for (int i = 0; i < 7; i++) dma_push(8'h70 + 8'(i));
        end
        @(negedge clk);
        total++; if (fifo_level !== 5'd7) begin bad++; $display("[TB] FAIL ar_pre_level got=%0d want=7", fifo_level); end
        total++; if (dma_wrout !== 1'b1) begin bad++; $display("[TB] FAIL ar_pre_ack got=%b want=1", dma_wrout); end
        #2;
        reset_n = 1'b0;
        dma_wrin = 1'b0;
        iowrin = 1'b0;
        #1;
        total++; if (fifo_level !== 5'd0) begin bad++; $display("[TB] FAIL ar_level got=%0d want=0", fifo_level); end
        total++; if (dma_wrout !== 1'b0) begin bad++; $display("[TB] FAIL ar_dma_ack got=%b want=0", dma_wrout); end
        total++; if (iowrout !== 1'b0) begin bad++; $display("[TB] FAIL ar_io_ack got=%b want=0", iowrout); end
        total++; if (sample_out !== 8'h80) begin bad++; $display("[TB] FAIL ar_sample got=%h want=80", sample_out); end
        total++; if (sample_stb !== 1'b0) begin bad++; $display("[TB] FAIL ar_stb got=%b want=0", sample_stb); end
        total++; if (underrun !== 1'b0) begin bad++; $display("[TB] FAIL ar_underrun got=%b want=0", underrun); end
        total++; if (irq_out !== 1'b0) begin bad++; $display("[TB] FAIL ar_irq got=%b want=0", irq_out); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++; if (fifo_level !== 5'd0) begin bad++; $display("[TB] FAIL ar_post_level got=%0d want=0", fifo_level); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_underrun();
        test_clear();
        test_flush_push();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
